// File: rtl/rat_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_pkg
// Description : Shared definitions for the RAT MCU I/O responder.
//               Holds the port address map, the default button count and
//               the 8-bit port data type.
// Revision    : 1.0 - initial release
// ============================================================================
package rat_io_pkg;

  typedef logic [7:0] io_port_t;

  // Default number of debounced button inputs
  localparam int NBTN_DEFAULT = 4;

  // Readable ports
  localparam io_port_t SWITCHES_ID = 8'h20;
  localparam io_port_t BTN_ID      = 8'h21;
  localparam io_port_t INT_STAT_ID = 8'h22;

  // Writable ports
  localparam io_port_t LEDS_ID     = 8'h40;
  localparam io_port_t SSEG_ID     = 8'h81;
  localparam io_port_t INT_MASK_ID = 8'h82;
  localparam io_port_t INT_ACK_ID  = 8'h83;

endpackage : rat_io_pkg
`default_nettype wire

// File: rtl/rat_io_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_responder_if
// Description : RAT MCU port bus between the MCU core and an I/O responder.
//   PORT_ID  - port address driven by the MCU
//   OUT_PORT - write data driven by the MCU
//   IO_STRB  - one-cycle write strobe per OUT instruction
//   IN_PORT  - read data returned by the responder
//   INT      - interrupt request returned by the responder
//   master   : MCU side;  slave : responder side
// Revision    : 1.0 - initial release
// ============================================================================
interface rat_io_responder_if;
  import rat_io_pkg::*;

  io_port_t PORT_ID;
  io_port_t OUT_PORT;
  logic     IO_STRB;
  io_port_t IN_PORT;
  logic     INT;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_PORT,
    input  INT
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_PORT,
    output INT
  );

endinterface : rat_io_responder_if
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer plus counter debouncer for one button.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   btn_raw - asynchronous button level
//   db      - debounced level (registered)
//   rise    - one-cycle pulse, high in the cycle whose closing edge
//             accepts a 0->1 transition of db
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn_raw,
  output logic      db,
  output logic      rise
);

  // A one-cycle debounce still needs a 1-bit counter to be legal
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = (r_sync2 != r_db);
  assign w_accept  = w_differs && (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign db = r_db;
  // Combinational so the interrupt logic can set PENDING on the accepting edge
  assign rise = w_accept && r_sync2;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : rat_io_responder
// Description : I/O responder for the RAT MCU port bus. Decodes OUT writes
//               into LED / seven-segment / interrupt registers, returns
//               switch, button and interrupt status on IN reads, and raises
//               INT on masked debounced button presses until acknowledged.
//   CLK      - system clock, rising edge
//   RESET    - synchronous active-high reset
//   bus      - MCU port bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT, INT)
//   SWITCHES - raw switch levels
//   BTN      - raw button levels
//   LEDS     - LED register
//   SSEG_VAL - seven-segment value register
// Revision    : 1.0 - initial release
// ============================================================================
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int NBTN      = NBTN_DEFAULT
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  rat_io_responder_if.slave      bus,
  input  wire logic [7:0]        SWITCHES,
  input  wire logic [NBTN-1:0]   BTN,
  output logic [7:0]             LEDS,
  output logic [7:0]             SSEG_VAL
);

  io_port_t        r_leds;
  io_port_t        r_sseg;
  logic [NBTN-1:0] r_mask;
  logic [NBTN-1:0] r_pending;
  logic            r_int;
  io_port_t        r_sw_meta;
  io_port_t        r_sw_sync;

  logic [NBTN-1:0] w_db;
  logic [NBTN-1:0] w_rise;
  logic            w_wr_leds;
  logic            w_wr_sseg;
  logic            w_wr_mask;
  logic            w_wr_ack;
  logic [NBTN-1:0] w_ack_bits;
  logic [NBTN-1:0] w_pending_nxt;
  io_port_t        w_in_port;

  // --------------------------------------------------------------------------
  // Button debouncers
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NBTN; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_db (
        .clk     (CLK),
        .rst     (RESET),
        .btn_raw (BTN[gi]),
        .db      (w_db[gi]),
        .rise    (w_rise[gi])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  assign w_wr_leds = bus.IO_STRB && (bus.PORT_ID == LEDS_ID);
  assign w_wr_sseg = bus.IO_STRB && (bus.PORT_ID == SSEG_ID);
  assign w_wr_mask = bus.IO_STRB && (bus.PORT_ID == INT_MASK_ID);
  assign w_wr_ack  = bus.IO_STRB && (bus.PORT_ID == INT_ACK_ID);

  // Acknowledge bits above NBTN have no pending flag and simply drop out
  assign w_ack_bits = w_wr_ack ? bus.OUT_PORT[NBTN-1:0] : '0;

  // Clear first, then set, so a press landing on the ack edge is kept
  assign w_pending_nxt = (r_pending & ~w_ack_bits) | (w_rise & r_mask);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_leds    <= '0;
      r_sseg    <= '0;
      r_mask    <= '0;
      r_pending <= '0;
      r_int     <= 1'b0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= SWITCHES;
      r_sw_sync <= r_sw_meta;
      if (w_wr_leds) begin
        r_leds <= bus.OUT_PORT;
      end
      if (w_wr_sseg) begin
        r_sseg <= bus.OUT_PORT;
      end
      if (w_wr_mask) begin
        r_mask <= bus.OUT_PORT[NBTN-1:0];
      end
      r_pending <= w_pending_nxt;
      // Registered copy of |PENDING, always in step with r_pending
      r_int     <= |w_pending_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_port = '0;
    case (bus.PORT_ID)
      SWITCHES_ID: w_in_port = r_sw_sync;
      BTN_ID:      w_in_port = io_port_t'(w_db);
      INT_STAT_ID: w_in_port = io_port_t'(r_pending);
      default:     w_in_port = '0;
    endcase
  end

  assign bus.IN_PORT = w_in_port;
  assign bus.INT     = r_int;
  assign LEDS        = r_leds;
  assign SSEG_VAL    = r_sseg;

endmodule : rat_io_responder
`default_nettype wire

// File: tb/tb_rat_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_io_responder
// Description : Directed self-checking bench for rat_io_responder
//               (DB_CYCLES = 4, NBTN = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_io_responder;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] leds;
  logic [7:0] sseg;

  int n_checks;
  int n_fails;

  rat_io_responder_if bus ();

  rat_io_responder #(
    .DB_CYCLES (4),
    .NBTN      (4)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .bus      (bus),
    .SWITCHES (sw),
    .BTN      (btn),
    .LEDS     (leds),
    .SSEG_VAL (sseg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
  endtask

  task automatic read_port(input string tag, input logic [7:0] id, input logic [7:0] exp);
    bus.PORT_ID = id;
    #1;
    check(tag, 32'(bus.IN_PORT), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    // Reset held with a competing LEDS write
    rst          = 1'b1;
    bus.IO_STRB  = 1'b1;
    bus.PORT_ID  = 8'h40;
    bus.OUT_PORT = 8'hFF;
    sw           = 8'h00;
    btn          = 4'h0;
    tick();
    tick();
    check("rst_leds", 32'(leds), 32'h00);
    check("rst_sseg", 32'(sseg), 32'h00);
    check("rst_int",  32'(bus.INT), 32'h0);
    rst         = 1'b0;
    bus.IO_STRB = 1'b0;
    read_port("rst_stat", 8'h22, 8'h00);

    // Writes
    io_write(8'h40, 8'hA5);
    check("leds_wr", 32'(leds), 32'hA5);
    bus.PORT_ID  = 8'h81;
    bus.OUT_PORT = 8'h3C;
    tick();
    check("sseg_nostrb", 32'(sseg), 32'h00);
    io_write(8'h81, 8'h3C);
    check("sseg_wr", 32'(sseg), 32'h3C);
    io_write(8'h99, 8'h11);
    check("unk_leds", 32'(leds), 32'hA5);
    check("unk_sseg", 32'(sseg), 32'h3C);

    // Switch synchronizer latency
    sw = 8'h5A;
    tick();
    read_port("sw_1clk", 8'h20, 8'h00);
    tick();
    read_port("sw_2clk", 8'h20, 8'h5A);
    read_port("rd_unk", 8'h40, 8'h00);

    // Masked press on BTN[0]: INT after edge k+5
    io_write(8'h82, 8'h01);
    btn = 4'h1;
    repeat (5) tick();
    check("int_k4", 32'(bus.INT), 32'h0);
    tick();
    check("int_k5", 32'(bus.INT), 32'h1);
    read_port("stat_b0", 8'h22, 8'h01);
    read_port("btn_b0", 8'h21, 8'h01);

    // Acknowledge
    io_write(8'h83, 8'h01);
    check("ack_int", 32'(bus.INT), 32'h0);
    read_port("ack_stat", 8'h22, 8'h00);

    // Three-cycle glitch on BTN[1]
    btn = 4'h3;
    repeat (3) tick();
    btn = 4'h1;
    repeat (4) tick();
    read_port("glitch_db", 8'h21, 8'h01);
    check("glitch_int", 32'(bus.INT), 32'h0);

    // Unmasked BTN[2]
    btn = 4'h5;
    repeat (6) tick();
    read_port("nomask_db", 8'h21, 8'h05);
    read_port("nomask_stat", 8'h22, 8'h00);
    check("nomask_int", 32'(bus.INT), 32'h0);

    // Release of BTN[0] does not interrupt
    btn = 4'h4;
    repeat (6) tick();
    read_port("rel_db", 8'h21, 8'h04);
    check("rel_int", 32'(bus.INT), 32'h0);

    // New BTN[0] acceptance on the same edge as an ack of bit 0
    btn = 4'h5;
    repeat (5) tick();
    check("same_pre", 32'(bus.INT), 32'h0);
    bus.PORT_ID  = 8'h83;
    bus.OUT_PORT = 8'h01;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
    check("same_int", 32'(bus.INT), 32'h1);
    read_port("same_stat", 8'h22, 8'h01);

    // Two buttons pending
    io_write(8'h82, 8'h03);
    btn = 4'h7;
    repeat (6) tick();
    read_port("multi_stat", 8'h22, 8'h03);
    check("multi_int", 32'(bus.INT), 32'h1);
    io_write(8'h83, 8'h01);
    check("multi_ack0", 32'(bus.INT), 32'h1);
    read_port("multi_st1", 8'h22, 8'h02);
    io_write(8'h83, 8'hFC);
    read_port("ack_hi", 8'h22, 8'h02);
    io_write(8'h82, 8'h00);
    read_port("mask_clr", 8'h22, 8'h02);
    io_write(8'h83, 8'h02);
    check("multi_done", 32'(bus.INT), 32'h0);

    // Reset in the middle of a debounce
    btn = 4'h0;
    repeat (6) tick();
    btn = 4'h1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_leds", 32'(leds), 32'h00);
    io_write(8'h82, 8'h01);   // this is edge r
    repeat (4) tick();
    check("mid_r4", 32'(bus.INT), 32'h0);
    tick();
    check("mid_r5", 32'(bus.INT), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_rat_io_responder
`default_nettype wire

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- I/O responder on the RAT MCU port bus, on the opposite side of the control unit's IO_STRB / INT_CU interface.
- Decodes PORT_ID for the MCU's IN/OUT instructions:
  - latches OUT_PORT writes into peripheral registers;
  - drives IN_PORT for reads.
- Debounces board buttons and raises INT, which feeds the control unit's INT_CU. INT stays high until software acknowledges it.
- Sits between the MCU top level and the Basys3 switches, buttons, LEDs and seven-segment display.

Parameters:
- DB_CYCLES, 4: consecutive cycles a synchronized button level must differ from the debounced state before it is accepted. Must be ≥1; the board build overrides it to 500000.
- NBTN, 4: number of button inputs.

Ports:
- CLK  in  1  system clock, rising-edge
- RESET  in  1  synchronous, active-high reset
- PORT_ID  in  8  port address from the MCU
- OUT_PORT  in  8  write data from the MCU
- IO_STRB  in  1  write strobe from the control unit; one cycle per OUT instruction
- IN_PORT  out  8  read data to the MCU; combinational from PORT_ID
- SWITCHES  in  8  raw asynchronous switch levels
- BTN  in  NBTN  raw asynchronous button levels
- LEDS  out  8  LED register
- SSEG_VAL  out  8  seven-segment value register
- INT  out  1  interrupt request to the control unit's INT_CU

Behaviour:
- Reset:
  - LEDS, SSEG_VAL, MASK, PENDING, synchronizer flops, debounced state and debounce counters are all 0; INT=0.
  - RESET has priority over IO_STRB in the same cycle.
- Port map (from rat_io_pkg):
  - SWITCHES_ID=0x20 (R)
  - BTN_ID=0x21 (R)
  - INT_STAT_ID=0x22 (R)
  - LEDS_ID=0x40 (W)
  - SSEG_ID=0x81 (W)
  - INT_MASK_ID=0x82 (W)
  - INT_ACK_ID=0x83 (W)
- Writes:
  - Qualified by IO_STRB=1 at the rising edge; the register updates on that edge and is visible the next cycle.
  - Unknown PORT_ID is ignored.
  - IO_STRB=0: no register changes, whatever PORT_ID/OUT_PORT are.
- Reads:
  - IN_PORT = SWITCHES_sync when PORT_ID=SWITCHES_ID.
  - IN_PORT = zero-extended debounced BTN when PORT_ID=BTN_ID.
  - IN_PORT = zero-extended PENDING when PORT_ID=INT_STAT_ID.
  - Otherwise IN_PORT=0x00. No strobe is needed for reads.
- Synchronizers: 2-flop on SWITCHES and each BTN bit; 2-cycle latency.
- Debounce (per button):
  - Counter width $clog2(DB_CYCLES).
  - If sync==db: counter<=0.
  - Else if counter==DB_CYCLES-1: db<=sync and counter<=0.
  - Else: counter++.
  - Counter never wraps; a glitch shorter than DB_CYCLES cycles leaves db unchanged.
- Interrupt:
  - A db 0→1 acceptance of bit i with MASK[i]=1 sets PENDING[i] on the same edge.
  - INT = |PENDING, registered-output equivalent.
  - A write to INT_ACK_ID clears PENDING bits where OUT_PORT bit=1 (write-1-to-clear); bits ≥NBTN are ignored.
  - Same-cycle set and ack of the same bit: set wins; the event is not lost.
  - Clearing MASK does not clear PENDING.
  - Release (1→0) never sets PENDING.
- Latency: BTN held high from edge k gives INT=1 after edge k+1+DB_CYCLES, i.e. visible in the following cycle.
- Multiple buttons pending: INT stays high until all PENDING bits are cleared.

Decomposition:
- Package rat_io_pkg:
  - port ID localparams;
  - NBTN default;
  - typedef io_port_t (logic [7:0]).
- Sub-module btn_debounce:
  - contents: synchronizer, counter, db state;
  - output: a one-cycle rise pulse;
  - instantiated NBTN times via generate.
- Top level holds:
  - the write decode;
  - LEDS / SSEG_VAL / MASK / PENDING;
  - the IN_PORT mux.

Test Plan (DB_CYCLES=4):
- Reset:
  - Stimulus: RESET=1 for 2 cycles while IO_STRB=1, PORT_ID=0x40, OUT_PORT=0xFF.
  - Response: LEDS=0x00, INT=0, IN_PORT=0x00 for PORT_ID=0x22.
- Write/read:
  - Stimulus: IO_STRB pulse with PORT_ID=0x40, OUT_PORT=0xA5. Then PORT_ID=0x81, 0x3C with IO_STRB=0.
  - Response: LEDS=0xA5 next cycle; SSEG_VAL stays 0x00.
  - Stimulus: SWITCHES=0x5A.
  - Response: after 2 cycles, IN_PORT=0x5A at PORT_ID=0x20.
- Debounce/interrupt:
  - Stimulus: MASK=0x01, then BTN[0] held high from edge k.
  - Response: INT rises after edge k+5; IN_PORT(0x22)=0x01; IN_PORT(0x21)=0x01.
- Glitch and mask:
  - Stimulus: BTN[1] high for 3 cycles.
  - Response: no db change, INT=0.
  - Stimulus: BTN[2] held with MASK[2]=0.
  - Response: db bit 2=1, PENDING=0, INT=0.
- Ack:
  - Stimulus: PENDING=0x01; write 0x01 to 0x83.
  - Response: INT=0 next cycle.
  - Stimulus: ack 0x01 on the same edge as a new BTN[0] acceptance.
  - Response: PENDING[0] stays 1, INT=1.
- Reset mid-debounce:
  - Stimulus: RESET asserted after 2 cycles of BTN high.
  - Response: counter restarts; INT rises 5 edges after reset release with BTN still high, i.e. after edge r+5 where r is the first edge with RESET=0.
